// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the WISC-SP20 instruction-fetch stage.
package fetch_pkg;

    localparam int INS_W = 16;

    localparam logic [INS_W-1:0] RESET_PC = 16'h0000;
    localparam logic [INS_W-1:0] NOP_INS  = 16'h0800;
    localparam logic [4:0]       HALT_OP  = 5'b00000;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_WAIT  = 3'd1,
        S_DRAIN = 3'd2,
        S_HOLD  = 3'd3,
        S_HALT  = 3'd4
    } state_e;

    function automatic logic [4:0] opcode(input logic [INS_W-1:0] ins);
        return ins[15:11];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory handshake between the fetch stage (master) and imem (slave).
interface fetch_unit_if;
    import fetch_pkg::*;

    logic [INS_W-1:0] imem_addr;
    logic             imem_rd;
    logic [INS_W-1:0] imem_data;
    logic             imem_stall;
    logic             imem_done;

    modport master (
        output imem_addr, imem_rd,
        input  imem_data, imem_stall, imem_done
    );

    modport slave (
        input  imem_addr, imem_rd,
        output imem_data, imem_stall, imem_done
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {ins, pc_plus2} skid buffer that catches a fetch completing while decode is stalled.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             unload,
    input  logic             clear,
    input  logic [INS_W-1:0] ins_d,
    input  logic [INS_W-1:0] pc_plus2_d,
    output logic [INS_W-1:0] ins_q,
    output logic [INS_W-1:0] pc_plus2_q,
    output logic             full
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

    // NOTE: the payload is deliberately not reset; it is only ever read while full is set.
    always_ff @(posedge clk) begin
        if (load) begin
            ins_q      <= ins_d;
            pc_plus2_q <= pc_plus2_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// WISC-SP20 fetch stage: PC, imem handshake FSM, skid buffer and IF/ID register.
// Optional macro FETCH_ALIGN_CHECK_EN adds fetch_err and halts on an odd PC.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = fetch_pkg::RESET_PC,
    parameter logic [15:0] NOP_INS  = fetch_pkg::NOP_INS,
    parameter logic [4:0]  HALT_OP  = fetch_pkg::HALT_OP
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_decode,
    input  logic                      flush_fetch,
    input  logic [fetch_pkg::INS_W-1:0] redirect_pc,
    fetch_unit_if.master              imem,
    output logic [fetch_pkg::INS_W-1:0] if_id_ins,
    output logic [fetch_pkg::INS_W-1:0] if_id_pc_plus2,
    output logic                      if_id_valid,
    output logic                      halted
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic                      fetch_err
`endif
);
    import fetch_pkg::*;

    localparam logic [2:0] FETCH = S_FETCH;
    localparam logic [2:0] WAIT  = S_WAIT;
    localparam logic [2:0] DRAIN = S_DRAIN;
    localparam logic [2:0] HOLD  = S_HOLD;
    localparam logic [2:0] HALT  = S_HALT;

    logic [2:0]       state;
    logic [2:0]       deliver_next;
    logic [INS_W-1:0] pc;
    logic [INS_W-1:0] pc_plus2;
    logic             misaligned;
    logic             deliver;
    logic             buf_full;
    logic             skid_load;
    logic             skid_unload;
    logic [INS_W-1:0] buf_ins;
    logic [INS_W-1:0] buf_pc_plus2;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = pc[0];
`else
    assign misaligned = 1'b0;
`endif

    assign pc_plus2       = pc + 16'd2;
    assign imem.imem_addr = pc;
    assign imem.imem_rd   = !rst && (state == FETCH) && !imem.imem_stall && !misaligned;
    assign halted         = (state == HALT);

    // A done only counts when it answers a request we actually have in flight.
    assign deliver     = imem.imem_done && (((state == FETCH) && imem.imem_rd) || (state == WAIT));
    assign skid_load   = !rst && !flush_fetch && deliver && stall_decode;
    assign skid_unload = !rst && !flush_fetch && buf_full && !stall_decode;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        deliver_next = FETCH;
        if (stall_decode) begin
            deliver_next = HOLD;
        end else if (opcode(imem.imem_data) == HALT_OP) begin
            deliver_next = HALT;
        end
    end

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (flush_fetch),
        .ins_d      (imem.imem_data),
        .pc_plus2_d (pc_plus2),
        .ins_q      (buf_ins),
        .pc_plus2_q (buf_pc_plus2),
        .full       (buf_full)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            if_id_ins      <= NOP_INS;
            if_id_pc_plus2 <= '0;
            if_id_valid    <= 1'b0;
        end else if (flush_fetch) begin
            pc             <= redirect_pc;
            if_id_ins      <= NOP_INS;
            if_id_pc_plus2 <= '0;
            if_id_valid    <= 1'b0;
            // An unanswered request must have its done swallowed before refetching.
            if (!imem.imem_done &&
                ((state == WAIT) || (state == DRAIN) || ((state == FETCH) && imem.imem_rd))) begin
                state <= DRAIN;
            end else begin
                state <= FETCH;
            end
        end else begin
            if (deliver) begin
                pc <= pc_plus2;
            end

            if (!stall_decode) begin
                if (deliver) begin
                    if_id_ins      <= imem.imem_data;
                    if_id_pc_plus2 <= pc_plus2;
                    if_id_valid    <= 1'b1;
                end else if (buf_full) begin
                    if_id_ins      <= buf_ins;
                    if_id_pc_plus2 <= buf_pc_plus2;
                    if_id_valid    <= 1'b1;
                end else begin
                    if_id_ins      <= NOP_INS;
                    if_id_pc_plus2 <= '0;
                    if_id_valid    <= 1'b0;
                end
            end

            case (state)
                FETCH: begin
                    if (misaligned) begin
                        state <= HALT;
                    end else if (imem.imem_rd) begin
                        state <= imem.imem_done ? deliver_next : WAIT;
                    end
                end
                WAIT: begin
                    if (imem.imem_done) begin
                        state <= deliver_next;
                    end
                end
                DRAIN: begin
                    if (imem.imem_done) begin
                        state <= FETCH;
                    end
                end
                HOLD: begin
                    // A HALT caught in the skid buffer still stops fetch once it issues.
                    if (!stall_decode) begin
                        state <= (opcode(buf_ins) == HALT_OP) ? HALT : FETCH;
                    end
                end
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst || flush_fetch) begin
            fetch_err <= 1'b0;
        end else if ((state == FETCH) && misaligned) begin
            fetch_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit; imem handshake is driven cycle by cycle.
module tb_fetch_unit;

    typedef struct {
        logic        sd;
        logic        fl;
        logic [15:0] rpc;
        logic        ms;
        logic        dn;
        logic [15:0] dat;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] ins;
        logic [15:0] pc2;
        logic        vld;
        logic        hlt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_decode;
    logic        flush_fetch;
    logic [15:0] redirect_pc;
    logic [15:0] if_id_ins;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_err;
`endif

    int errors = 0;
    int checks = 0;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall_decode   (stall_decode),
        .flush_fetch    (flush_fetch),
        .redirect_pc    (redirect_pc),
        .imem           (bus),
        .if_id_ins      (if_id_ins),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .if_id_valid    (if_id_valid),
        .halted         (halted)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_err      (fetch_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic sd, input logic fl, input logic [15:0] rpc,
                                input logic ms, input logic dn, input logic [15:0] dat,
                                input logic rd, input logic [15:0] addr, input logic [15:0] ins,
                                input logic [15:0] pc2, input logic vld, input logic hlt);
        vec_t v;
        v.sd = sd; v.fl = fl; v.rpc = rpc; v.ms = ms; v.dn = dn; v.dat = dat;
        v.rd = rd; v.addr = addr; v.ins = ins; v.pc2 = pc2; v.vld = vld; v.hlt = hlt;
        return v;
    endfunction

    // Drive at negedge, check combinational handshake mid-cycle, registered outputs after the edge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        stall_decode   = v.sd;
        flush_fetch    = v.fl;
        redirect_pc    = v.rpc;
        bus.imem_stall = v.ms;
        bus.imem_done  = v.dn;
        bus.imem_data  = v.dat;
        #1;
        check({tag, " imem_rd"},   16'(bus.imem_rd), 16'(v.rd));
        check({tag, " imem_addr"}, bus.imem_addr,    v.addr);
        @(posedge clk);
        #1;
        check({tag, " if_id_ins"},      if_id_ins,         v.ins);
        check({tag, " if_id_pc_plus2"}, if_id_pc_plus2,    v.pc2);
        check({tag, " if_id_valid"},    16'(if_id_valid),  16'(v.vld));
        check({tag, " halted"},         16'(halted),       16'(v.hlt));
    endtask

    vec_t vecs[$];
    int   rd_count;

    initial begin
        rst            = 1'b1;
        stall_decode   = 1'b0;
        flush_fetch    = 1'b0;
        redirect_pc    = 16'h0000;
        bus.imem_stall = 1'b0;
        bus.imem_done  = 1'b0;
        bus.imem_data  = 16'h0000;

        // Zero-latency memory from PC 0
        vecs.push_back(mk(0,0,16'h0000,0,1,16'h4100, 1,16'h0000, 16'h4100,16'h0002,1,0));
        vecs.push_back(mk(0,0,16'h0000,0,1,16'h4102, 1,16'h0002, 16'h4102,16'h0004,1,0));
        vecs.push_back(mk(0,0,16'h0000,0,1,16'h4104, 1,16'h0004, 16'h4104,16'h0006,1,0));
        // Three-cycle latency: one request, bubbles, delivery every fourth cycle
        vecs.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0006, 16'h0800,16'h0000,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,16'h0000, 0,16'h0006, 16'h0800,16'h0000,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,16'h0000, 0,16'h0006, 16'h0800,16'h0000,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,1,16'h4106, 0,16'h0006, 16'h4106,16'h0008,1,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0008, 16'h0800,16'h0000,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,16'h0000, 0,16'h0008, 16'h0800,16'h0000,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,16'h0000, 0,16'h0008, 16'h0800,16'h0000,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,1,16'h4108, 0,16'h0008, 16'h4108,16'h000A,1,0));
        // Memory busy: no request, stay
        vecs.push_back(mk(0,0,16'h0000,1,0,16'h0000, 0,16'h000A, 16'h0800,16'h0000,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,1,16'h410A, 1,16'h000A, 16'h410A,16'h000C,1,0));
        // Decode stall for two cycles across a completing fetch
        vecs.push_back(mk(1,0,16'h0000,0,1,16'h410C, 1,16'h000C, 16'h410A,16'h000C,1,0));
        vecs.push_back(mk(1,0,16'h0000,0,0,16'h0000, 0,16'h000E, 16'h410A,16'h000C,1,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,16'h0000, 0,16'h000E, 16'h410C,16'h000E,1,0));
        vecs.push_back(mk(0,0,16'h0000,0,1,16'h410E, 1,16'h000E, 16'h410E,16'h0010,1,0));
        // HALT at 0x0010, stray done ignored, flush to 0x0020 resumes
        vecs.push_back(mk(0,0,16'h0000,0,1,16'h0000, 1,16'h0010, 16'h0000,16'h0012,1,1));
        vecs.push_back(mk(0,0,16'h0000,0,0,16'h0000, 0,16'h0012, 16'h0800,16'h0000,0,1));
        vecs.push_back(mk(0,0,16'h0000,0,1,16'h4112, 0,16'h0012, 16'h0800,16'h0000,0,1));
        vecs.push_back(mk(0,1,16'h0020,0,0,16'h0000, 0,16'h0012, 16'h0800,16'h0000,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,1,16'h4120, 1,16'h0020, 16'h4120,16'h0022,1,0));
        // Flush while waiting: the stale done is drained
        vecs.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0022, 16'h0800,16'h0000,0,0));
        vecs.push_back(mk(0,1,16'h0040,0,0,16'h0000, 0,16'h0022, 16'h0800,16'h0000,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,16'h0000, 0,16'h0040, 16'h0800,16'h0000,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,1,16'h4122, 0,16'h0040, 16'h0800,16'h0000,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,1,16'h4140, 1,16'h0040, 16'h4140,16'h0042,1,0));
        // Flush coincident with done, overriding a decode stall
        vecs.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0042, 16'h0800,16'h0000,0,0));
        vecs.push_back(mk(1,1,16'hFFFE,0,1,16'h4142, 0,16'h0042, 16'h0800,16'h0000,0,0));
        // PC wrap at 0xFFFE
        vecs.push_back(mk(0,0,16'h0000,0,1,16'h41FE, 1,16'hFFFE, 16'h41FE,16'h0000,1,0));
        vecs.push_back(mk(0,0,16'h0000,0,1,16'h4200, 1,16'h0000, 16'h4200,16'h0002,1,0));
        // Flush in FETCH with a request just issued goes through DRAIN
        vecs.push_back(mk(0,1,16'h0050,0,0,16'h0000, 1,16'h0002, 16'h0800,16'h0000,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,1,16'h4102, 0,16'h0050, 16'h0800,16'h0000,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,1,16'h4150, 1,16'h0050, 16'h4150,16'h0052,1,0));
        // Stall while waiting, completion lands in the skid buffer
        vecs.push_back(mk(1,0,16'h0000,0,0,16'h0000, 1,16'h0052, 16'h4150,16'h0052,1,0));
        vecs.push_back(mk(1,0,16'h0000,0,1,16'h4152, 0,16'h0052, 16'h4150,16'h0052,1,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,16'h0000, 0,16'h0054, 16'h4152,16'h0054,1,0));
        // HALT caught in the skid buffer
        vecs.push_back(mk(1,0,16'h0000,0,1,16'h0000, 1,16'h0054, 16'h4152,16'h0054,1,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,16'h0000, 0,16'h0056, 16'h0000,16'h0056,1,1));
        vecs.push_back(mk(0,0,16'h0000,0,0,16'h0000, 0,16'h0056, 16'h0800,16'h0000,0,1));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst imem_rd",        16'(bus.imem_rd),   16'h0000);
        check("rst if_id_ins",      if_id_ins,          16'h0800);
        check("rst if_id_pc_plus2", if_id_pc_plus2,     16'h0000);
        check("rst if_id_valid",    16'(if_id_valid),   16'h0000);
        check("rst halted",         16'(halted),        16'h0000);
`ifdef FETCH_ALIGN_CHECK_EN
        check("rst fetch_err",      16'(fetch_err),     16'h0000);
`endif
        @(negedge clk);
        rst            = 1'b0;
        bus.imem_stall = 1'b1;
        #1;
        check("post-rst imem_addr", bus.imem_addr,    16'h0000);
        check("post-rst imem_rd",   16'(bus.imem_rd), 16'h0000);
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // No further requests while halted
        rd_count = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            stall_decode = 1'b0; flush_fetch = 1'b0;
            bus.imem_stall = 1'b0; bus.imem_done = 1'b0;
            #1;
            if (bus.imem_rd) rd_count++;
        end
        check("halt rd count", 16'(rd_count), 16'h0000);

        // Redirect to an odd address
        apply(mk(0,1,16'h0003,0,0,16'h0000, 0,16'h0056, 16'h0800,16'h0000,0,0), "odd flush");
`ifdef FETCH_ALIGN_CHECK_EN
        apply(mk(0,0,16'h0000,0,0,16'h0000, 0,16'h0003, 16'h0800,16'h0000,0,1), "odd fetch");
        check("fetch_err set", 16'(fetch_err), 16'h0001);
        apply(mk(0,0,16'h0000,0,1,16'h1234, 0,16'h0003, 16'h0800,16'h0000,0,1), "odd hold");
        check("fetch_err sticky", 16'(fetch_err), 16'h0001);
        apply(mk(0,1,16'h0060,1,0,16'h0000, 0,16'h0003, 16'h0800,16'h0000,0,0), "odd clear");
        check("fetch_err cleared", 16'(fetch_err), 16'h0000);
`else
        apply(mk(0,0,16'h0000,0,1,16'h4303, 1,16'h0003, 16'h4303,16'h0005,1,0), "odd fetch");
        apply(mk(0,1,16'h0060,1,0,16'h0000, 0,16'h0005, 16'h0800,16'h0000,0,0), "odd clear");
`endif

        // Reset with a read outstanding; a late done must be ignored
        apply(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0060, 16'h0800,16'h0000,0,0), "pre-rst req");
        @(negedge clk);
        rst = 1'b1;
        bus.imem_stall = 1'b0; bus.imem_done = 1'b0;
        #1;
        check("mid-rst imem_rd", 16'(bus.imem_rd), 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        bus.imem_stall = 1'b1; bus.imem_done = 1'b1; bus.imem_data = 16'hDEAD;
        #1;
        check("late done imem_rd",   16'(bus.imem_rd), 16'h0000);
        check("late done imem_addr", bus.imem_addr,    16'h0000);
        @(posedge clk);
        #1;
        check("late done if_id_valid", 16'(if_id_valid), 16'h0000);
        check("late done if_id_ins",   if_id_ins,        16'h0800);
        apply(mk(0,0,16'h0000,0,1,16'h4300, 1,16'h0000, 16'h4300,16'h0002,1,0), "post-rst fetch");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
